// File: rtl/arbitro_raiz.sv
// Round-robin front end that shares a single square-root unit among N_REQ requesters.
// It launches the unit, waits for done (bounded by TIMEOUT), delivers the result and drains done.
module arbitro_raiz #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int RES_W   = 8,
  parameter int TIMEOUT = 63
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_op,
  output logic [N_REQ-1:0]       ack,
  output logic [RES_W-1:0]       result,
  output logic                   err,
  output logic                   busy,
  output logic                   out_init,
  output logic [WIDTH-1:0]       out_operand,
  output logic                   out_abort,
  input  logic                   in_done,
  input  logic [RES_W-1:0]       in_result
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DELIVER, DRAIN, ABORT} state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr, id, gnt_id;
  logic            gnt_vld;
  logic [WIDTH-1:0] opnd;
  logic [RES_W-1:0] res_q;
  logic [TW-1:0]    timer;
  logic             tmo;

  assign tmo = (timer == TW'(TIMEOUT));

  // Walk downwards so the nearest requester after ptr is the last (winning) write.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_vld) state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT:    if (in_done) state_nx = DELIVER;
               else if (tmo) state_nx = ABORT;
      DELIVER: state_nx = DRAIN;
      DRAIN:   if (!in_done) state_nx = IDLE;
      ABORT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= IDW'(N_REQ - 1);
      id    <= '0;
      opnd  <= '0;
      res_q <= '0;
      timer <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (gnt_vld) begin
          id   <= gnt_id;
          ptr  <= gnt_id;
          opnd <= req_op[gnt_id*WIDTH +: WIDTH];
        end
        LAUNCH: timer <= '0;
        WAIT: begin
          if (in_done) res_q <= in_result;
          else if (!tmo) timer <= timer + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Every output is a decode of state plus registered fields.
  assign busy        = (state != IDLE);
  assign out_init    = (state == LAUNCH);
  assign out_abort   = (state == ABORT);
  assign err         = (state == ABORT);
  assign out_operand = opnd;
  assign result      = (state == DELIVER) ? res_q : '0;
  assign ack         = (state == DELIVER || state == ABORT) ? (N_REQ'(1) << id) : '0;

endmodule

// File: tb/tb_arbitro_raiz.sv
// Bench for arbitro_raiz: behavioural sqrt unit, expected acks queued at stimulus time
// and popped when the DUT pulses ack.
module tb_arbitro_raiz;
  localparam int N_REQ = 4, WIDTH = 16, RES_W = 8, TIMEOUT = 63;

  logic                   clk = 0;
  logic                   rst = 0;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*WIDTH-1:0] req_op = '0;
  logic [N_REQ-1:0]       ack;
  logic [RES_W-1:0]       result;
  logic                   err, busy, out_init, out_abort;
  logic [WIDTH-1:0]       out_operand;
  logic                   in_done;
  logic [RES_W-1:0]       in_result;

  arbitro_raiz #(.N_REQ(N_REQ), .WIDTH(WIDTH), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .ack(ack), .result(result),
    .err(err), .busy(busy), .out_init(out_init), .out_operand(out_operand),
    .out_abort(out_abort), .in_done(in_done), .in_result(in_result)
  );

  always #5 clk = ~clk;

  function automatic logic [RES_W-1:0] isqrt(input logic [WIDTH-1:0] x);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return RES_W'(r);
  endfunction

  // Behavioural sqrt unit: done rises model_d+1 cycles after the init cycle, held model_h cycles.
  int   model_d = 20, model_h = 11;
  bit   model_hang = 0;
  int   cnt, hold;
  logic [WIDTH-1:0] op_m;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_done <= 0; in_result <= '0; cnt <= 0; hold <= 0; op_m <= '0;
    end else if (out_abort) begin
      in_done <= 0; cnt <= 0; hold <= 0;
    end else if (out_init) begin
      cnt <= model_d; op_m <= out_operand;
    end else if (cnt > 1) cnt <= cnt - 1;
    else if (cnt == 1) begin
      cnt <= 0;
      if (!model_hang) begin in_done <= 1; in_result <= isqrt(op_m); hold <= model_h; end
    end else if (hold > 1) hold <= hold - 1;
    else if (hold == 1) begin hold <= 0; in_done <= 0; end
  end

  typedef struct { logic [N_REQ-1:0] ack; logic [RES_W-1:0] res; logic err; } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0;
  int cyc = 0, n_init = 0, n_ack = 0, init_in_done = 0;
  int last_init = 0, last_ack = 0, last_abort = 0;
  bit auto_drop = 1;

  function automatic exp_t mk(input logic [N_REQ-1:0] a, input logic [RES_W-1:0] r, input logic e);
    exp_t x; x.ack = a; x.res = r; x.err = e; return x;
  endfunction

  // One cycle: sample at negedge, pop the scoreboard on ack, requesters drop req on ack.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (out_init) begin n_init++; last_init = cyc; if (in_done) init_in_done++; end
    if (out_abort) last_abort = cyc;
    if (ack != '0) begin
      n_ack++; last_ack = cyc; total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL sb_unexpected ack=%b result=%0d err=%b", ack, result, err);
      end else begin
        e = exp_q.pop_front();
        if (ack !== e.ack || result !== e.res || err !== e.err) begin
          bad++;
          $display("FAIL sb_ack got ack=%b result=%0d err=%b want ack=%b result=%0d err=%b",
                   ack, result, err, e.ack, e.res, e.err);
        end
      end
      if (auto_drop) req = req & ~ack;
    end
  endtask

  task automatic wait_init(input int budget);
    int n0 = n_init;
    for (int i = 0; i < budget && n_init == n0; i++) tick();
    if (n_init == n0) begin total++; bad++; $display("FAIL init_timeout got none want out_init"); end
  endtask

  task automatic wait_acks(input int target, input int budget);
    for (int i = 0; i < budget && n_ack < target; i++) tick();
    if (n_ack < target) begin total++; bad++; $display("FAIL ack_timeout got %0d want %0d", n_ack, target); end
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] v);
    req_op[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic test_reset();
    rst = 0; req = '0;
    repeat (3) tick();
    total++;
    if ({ack, result, err, busy, out_init, out_abort, out_operand} !== '0) begin
      bad++; $display("FAIL reset_outputs got ack=%b res=%0d err=%b busy=%b init=%b abort=%b op=%0d want 0",
                      ack, result, err, busy, out_init, out_abort, out_operand);
    end
    rst = 1;
    repeat (3) tick();
    total++;
    if (busy !== 1'b0 || out_init !== 1'b0) begin
      bad++; $display("FAIL idle_no_req got busy=%b init=%b want 0 0", busy, out_init);
    end
  endtask

  task automatic test_single();
    int n0 = n_init, t;
    model_d = 20; model_h = 11; auto_drop = 1;
    set_op(0, 16'd81); req = 4'b0001;
    exp_q.push_back(mk(4'b0001, isqrt(16'd81), 1'b0));
    wait_init(10);
    t = last_init;
    total++;
    if (out_operand !== 16'd81) begin bad++; $display("FAIL single_operand got %0d want 81", out_operand); end
    wait_acks(n_ack + 1, 100);
    total++;
    if (last_ack - t != 22) begin bad++; $display("FAIL single_latency got %0d want 22", last_ack - t); end
    tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_drain got %b want 1", busy); end
    for (int i = 0; i < 40 && busy; i++) tick();
    total++;
    if (cyc - t != 33) begin bad++; $display("FAIL single_busy_clear got %0d want 33", cyc - t); end
    total++;
    if (n_init - n0 != 1) begin bad++; $display("FAIL single_init_count got %0d want 1", n_init - n0); end
  endtask

  task automatic test_simultaneous();
    int n0;
    logic [WIDTH-1:0] ops [4] = '{16'd4, 16'd9, 16'd16, 16'd25};
    rst = 0; tick();
    model_d = 5; model_h = 3; auto_drop = 1;
    for (int i = 0; i < 4; i++) begin
      set_op(i, ops[i]);
      exp_q.push_back(mk(N_REQ'(1) << i, isqrt(ops[i]), 1'b0));
    end
    req = 4'b1111;
    tick(); rst = 1;
    n0 = n_init; init_in_done = 0;
    wait_acks(n_ack + 4, 400);
    total++;
    if (n_init - n0 != 4) begin bad++; $display("FAIL simul_init_count got %0d want 4", n_init - n0); end
    total++;
    if (init_in_done != 0) begin bad++; $display("FAIL simul_init_during_done got %0d want 0", init_in_done); end
  endtask

  task automatic test_fairness();
    int a0;
    auto_drop = 0; model_d = 4; model_h = 2;
    set_op(0, 16'd36); set_op(2, 16'd100);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(4'b0001, isqrt(16'd36), 1'b0));
      exp_q.push_back(mk(4'b0100, isqrt(16'd100), 1'b0));
    end
    req = 4'b0101;
    a0 = n_ack;
    wait_acks(a0 + 4, 400);
    req = '0;
    repeat (15) tick();
    total++;
    if (n_ack - a0 != 4 || busy !== 1'b0) begin
      bad++; $display("FAIL fair_ack_count got %0d busy=%b want 4 busy=0", n_ack - a0, busy);
    end
    auto_drop = 1;
  endtask

  task automatic test_timeout();
    int t;
    model_hang = 1; model_d = 5; model_h = 2;
    set_op(1, 16'd50); req = 4'b0010;
    exp_q.push_back(mk(4'b0010, '0, 1'b1));
    wait_init(10);
    t = last_init;
    wait_acks(n_ack + 1, 200);
    total++;
    if (last_ack - t != 65) begin bad++; $display("FAIL tmo_latency got %0d want 65", last_ack - t); end
    total++;
    if (last_abort != last_ack) begin bad++; $display("FAIL tmo_abort_cycle got %0d want %0d", last_abort, last_ack); end
    model_hang = 0;
    set_op(3, 16'd144); req = 4'b1000;
    exp_q.push_back(mk(4'b1000, isqrt(16'd144), 1'b0));
    wait_acks(n_ack + 1, 100);
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    model_d = 30; model_h = 2;
    set_op(0, 16'd64); set_op(1, 16'd121); req = 4'b0001;
    wait_init(10);
    repeat (10) tick();
    req = 4'b0011;
    rst = 0;
    #1;
    total++;
    if ({ack, result, err, busy, out_init, out_abort, out_operand} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs got ack=%b busy=%b op=%0d want 0", ack, busy, out_operand);
    end
    tick(); tick();
    exp_q.push_back(mk(4'b0001, isqrt(16'd64), 1'b0));
    exp_q.push_back(mk(4'b0010, isqrt(16'd121), 1'b0));
    rst = 1;
    wait_init(10);
    total++;
    if (out_operand !== 16'd64) begin bad++; $display("FAIL rst_mid_first_grant got %0d want 64", out_operand); end
    wait_acks(n_ack + 2, 300);
    repeat (6) tick();
  endtask

  task automatic test_early_drop();
    int a0, i0;
    auto_drop = 0; model_d = 8; model_h = 2;
    set_op(1, 16'd49); req = 4'b0010;
    exp_q.push_back(mk(4'b0010, isqrt(16'd49), 1'b0));
    wait_init(10);
    tick();
    req = '0;
    a0 = n_ack; i0 = n_init;
    wait_acks(a0 + 1, 100);
    repeat (20) tick();
    total++;
    if (n_ack - a0 != 1 || n_init != i0) begin
      bad++; $display("FAIL early_drop_regrant got acks=%0d inits=%0d want 1 0", n_ack - a0, n_init - i0);
    end
    auto_drop = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_early_drop();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got hang want finish");
    $fatal(1, "global timeout");
  end
endmodule
